// File: rtl/regfile_sb.sv
// ============================================================================
// Module   : regfile_sb
// Purpose  : Register file with NRD combinational read ports, one write port
//            and a 2-bit pending-write scoreboard per register. Optional
//            same-cycle write-to-read forwarding under REGFILE_BYPASS_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module regfile_sb #(
    parameter int XLEN = 32,
    parameter int NREG = 32,
    parameter int NRD  = 2,
    localparam int AW  = $clog2(NREG)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NRD*AW-1:0]   raddr,
    output logic [NRD*XLEN-1:0] rdata,
    output logic [NRD-1:0]      rbusy,
    input  logic                wen,
    input  logic [AW-1:0]       waddr,
    input  logic [XLEN-1:0]     wdata,
    input  logic                iss_en,
    input  logic [AW-1:0]       iss_addr,
    output logic                iss_rdy,
    input  logic                flush
);

    logic [XLEN-1:0] r_rf [NREG];
    logic [1:0]      r_pc [NREG];

    logic            w_waddr_in;
    logic            w_iss_in;
    logic            w_wr_hit;
    logic [1:0]      w_iss_pc;
    logic [NREG-1:0] w_inc;
    logic [NREG-1:0] w_dec;

    // Range checks collapse to constants when NREG fills the address space.
    if (NREG == (1 << AW)) begin : g_full_range
        assign w_waddr_in = 1'b1;
        assign w_iss_in   = 1'b1;
    end else begin : g_part_range
        assign w_waddr_in = ({1'b0, waddr}    < (AW+1)'(NREG));
        assign w_iss_in   = ({1'b0, iss_addr} < (AW+1)'(NREG));
    end

    assign w_wr_hit = wen && w_waddr_in && (waddr != '0);
    assign w_iss_pc = (w_iss_in && iss_addr != '0) ? r_pc[iss_addr] : 2'd0;

    // A full counter may still accept an issue if one write retires alongside.
    assign iss_rdy = !((w_iss_pc == 2'd3) && !(wen && waddr == iss_addr));

    for (genvar r = 0; r < NREG; r++) begin : g_cnt
        if (r == 0) begin : g_r0
            assign w_inc[r] = 1'b0;
            assign w_dec[r] = 1'b0;
        end else begin : g_rn
            assign w_inc[r] = iss_en && iss_rdy && w_iss_in && (iss_addr == AW'(r)) && !flush;
            assign w_dec[r] = w_wr_hit && (waddr == AW'(r)) && (r_pc[r] != 2'd0) && !flush;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int r = 0; r < NREG; r++) begin
                r_rf[r] <= '0;
                r_pc[r] <= 2'd0;
            end
        end else begin
            if (w_wr_hit) begin
                r_rf[waddr] <= wdata;
            end
            for (int r = 1; r < NREG; r++) begin
                if (flush) begin
                    r_pc[r] <= 2'd0;
                end else if (w_inc[r] && !w_dec[r]) begin
                    r_pc[r] <= r_pc[r] + 2'd1;
                end else if (!w_inc[r] && w_dec[r]) begin
                    r_pc[r] <= r_pc[r] - 2'd1;
                end
            end
        end
    end

    for (genvar i = 0; i < NRD; i++) begin : g_rd
        logic [AW-1:0]   w_ra;
        logic            w_ra_in;
        logic            w_ra_ok;
        logic [1:0]      w_pc;
        logic [XLEN-1:0] w_data;

        assign w_ra = raddr[i*AW +: AW];

        if (NREG == (1 << AW)) begin : g_full_range
            assign w_ra_in = 1'b1;
        end else begin : g_part_range
            assign w_ra_in = ({1'b0, w_ra} < (AW+1)'(NREG));
        end

        assign w_ra_ok = w_ra_in && (w_ra != '0);
        assign w_pc    = w_ra_ok ? r_pc[w_ra] : 2'd0;
        assign w_data  = w_ra_ok ? r_rf[w_ra] : '0;

`ifdef REGFILE_BYPASS_EN
        logic       w_fwd;
        logic       w_rd_inc;
        logic       w_rd_dec;
        logic [2:0] w_nxt;

        assign w_fwd    = w_wr_hit && (waddr == w_ra);
        assign w_rd_inc = iss_en && iss_rdy && (iss_addr == w_ra);
        assign w_rd_dec = w_fwd && (w_pc != 2'd0);
        // Busy reflects the count this register will hold after the edge.
        assign w_nxt    = {1'b0, w_pc} + {2'b00, w_rd_inc} - {2'b00, w_rd_dec};

        assign rdata[i*XLEN +: XLEN] = w_fwd ? wdata : w_data;
        assign rbusy[i]              = w_ra_ok && !flush && (w_nxt != 3'd0);
`else
        assign rdata[i*XLEN +: XLEN] = w_data;
        assign rbusy[i]              = (w_pc != 2'd0);
`endif
    end

endmodule

`default_nettype wire

// File: tb/tb_regfile_sb.sv
// ============================================================================
// Module   : tb_regfile_sb
// Purpose  : Self-checking bench for regfile_sb against a behavioural model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_regfile_sb;

    localparam int XLEN = 32;
    localparam int NREG = 32;
    localparam int NRD  = 2;
    localparam int AW   = 5;

    logic                clk = 1'b0;
    logic                rst;
    logic [NRD*AW-1:0]   raddr;
    logic [NRD*XLEN-1:0] rdata;
    logic [NRD-1:0]      rbusy;
    logic                wen;
    logic [AW-1:0]       waddr;
    logic [XLEN-1:0]     wdata;
    logic                iss_en;
    logic [AW-1:0]       iss_addr;
    logic                iss_rdy;
    logic                flush;

    int n_vec = 0;
    int n_err = 0;

    logic [XLEN-1:0] m_rf [NREG];
    int              m_pc [NREG];

    regfile_sb #(.XLEN(XLEN), .NREG(NREG), .NRD(NRD)) dut (
        .clk(clk), .rst(rst), .raddr(raddr), .rdata(rdata), .rbusy(rbusy),
        .wen(wen), .waddr(waddr), .wdata(wdata), .iss_en(iss_en),
        .iss_addr(iss_addr), .iss_rdy(iss_rdy), .flush(flush)
    );

    always #5 clk = ~clk;

    function automatic logic m_iss_rdy();
        if (iss_addr == 0) return 1'b1;
        return !(m_pc[iss_addr] == 3 && !(wen && waddr == iss_addr));
    endfunction

    function automatic int m_next_pc(int r);
        int inc, dec;
        if (r == 0 || flush) return 0;
        inc = (iss_en && m_iss_rdy() && iss_addr == r) ? 1 : 0;
        dec = (wen && waddr == r && m_pc[r] != 0) ? 1 : 0;
        return m_pc[r] + inc - dec;
    endfunction

    function automatic logic [XLEN-1:0] m_rdata(int a);
        if (a == 0) return '0;
`ifdef REGFILE_BYPASS_EN
        if (wen && waddr == a) return wdata;
`endif
        return m_rf[a];
    endfunction

    function automatic logic m_rbusy(int a);
        if (a == 0) return 1'b0;
`ifdef REGFILE_BYPASS_EN
        return m_next_pc(a) != 0;
`else
        return m_pc[a] != 0;
`endif
    endfunction

    task automatic mdl_clock();
        int              nxt [NREG];
        logic            do_w;
        int              wa;
        logic [XLEN-1:0] wd;
        for (int r = 0; r < NREG; r++) nxt[r] = m_next_pc(r);
        do_w = wen && waddr != 0;
        wa   = waddr;
        wd   = wdata;
        @(posedge clk);
        for (int r = 0; r < NREG; r++) m_pc[r] = nxt[r];
        if (do_w) m_rf[wa] = wd;
        #1;
    endtask

    task automatic set_in(logic we, int wa, logic [XLEN-1:0] wd, logic ie, int ia, logic fl);
        wen = we; waddr = AW'(wa); wdata = wd;
        iss_en = ie; iss_addr = AW'(ia); flush = fl;
    endtask

    task automatic set_rd(int a0, int a1);
        raddr[0 +: AW]  = AW'(a0);
        raddr[AW +: AW] = AW'(a1);
    endtask

    task automatic model_reset();
        for (int r = 0; r < NREG; r++) begin
            m_rf[r] = '0;
            m_pc[r] = 0;
        end
    endtask

    task automatic test_reset();
        set_in(1'b1, 5, 32'hDEADBEEF, 1'b1, 7, 1'b0);
        mdl_clock();
        set_in(1'b0, 0, '0, 1'b0, 7, 1'b0);
        set_rd(5, 7);
        #1;
        n_vec++;
        if (rdata[0 +: XLEN] !== m_rdata(5)) begin
            n_err++; $display("FAIL reset_pre_rdata got %h want %h", rdata[0 +: XLEN], m_rdata(5));
        end
        n_vec++;
        if (rbusy[1] !== m_rbusy(7)) begin
            n_err++; $display("FAIL reset_pre_rbusy got %b want %b", rbusy[1], m_rbusy(7));
        end
        #1 rst = 1'b0;
        model_reset();
        #1;
        n_vec++;
        if (rdata[0 +: XLEN] !== 32'h0) begin
            n_err++; $display("FAIL reset_rdata got %h want 0", rdata[0 +: XLEN]);
        end
        n_vec++;
        if (rbusy[1] !== 1'b0) begin
            n_err++; $display("FAIL reset_rbusy got %b want 0", rbusy[1]);
        end
        n_vec++;
        if (iss_rdy !== 1'b1) begin
            n_err++; $display("FAIL reset_iss_rdy got %b want 1", iss_rdy);
        end
        rst = 1'b1;
        mdl_clock();
    endtask

    task automatic test_r0();
        set_in(1'b1, 0, 32'hFFFFFFFF, 1'b1, 0, 1'b0);
        set_rd(0, 0);
        #1;
        n_vec++;
        if (iss_rdy !== 1'b1) begin
            n_err++; $display("FAIL r0_iss_rdy got %b want 1", iss_rdy);
        end
        mdl_clock();
        set_in(1'b0, 0, '0, 1'b0, 0, 1'b0);
        #1;
        n_vec++;
        if (rdata[0 +: XLEN] !== 32'h0) begin
            n_err++; $display("FAIL r0_rdata got %h want 0", rdata[0 +: XLEN]);
        end
        n_vec++;
        if (rbusy[0] !== 1'b0) begin
            n_err++; $display("FAIL r0_rbusy got %b want 0", rbusy[0]);
        end
        mdl_clock();
    endtask

    task automatic test_saturation();
        set_rd(3, 0);
        for (int k = 0; k < 4; k++) begin
            set_in(1'b0, 0, '0, 1'b1, 3, 1'b0);
            #1;
            n_vec++;
            if (iss_rdy !== m_iss_rdy()) begin
                n_err++; $display("FAIL sat_issue%0d got %b want %b", k, iss_rdy, m_iss_rdy());
            end
            n_vec++;
            if (iss_rdy !== (k < 3)) begin
                n_err++; $display("FAIL sat_limit%0d got %b want %b", k, iss_rdy, k < 3);
            end
            mdl_clock();
        end
        set_in(1'b1, 3, 32'h00000333, 1'b1, 3, 1'b0);
        #1;
        n_vec++;
        if (iss_rdy !== 1'b1) begin
            n_err++; $display("FAIL sat_retire_issue got %b want 1", iss_rdy);
        end
        mdl_clock();
        for (int k = 0; k < 3; k++) begin
            set_in(1'b1, 3, 32'h00000300 + k, 1'b0, 0, 1'b0);
            #1;
            n_vec++;
            if (rbusy[0] !== m_rbusy(3)) begin
                n_err++; $display("FAIL sat_wb%0d_rbusy got %b want %b", k, rbusy[0], m_rbusy(3));
            end
            mdl_clock();
        end
        set_in(1'b0, 0, '0, 1'b0, 0, 1'b0);
        #1;
        n_vec++;
        if (rbusy[0] !== 1'b0 || rdata[0 +: XLEN] !== 32'h00000302) begin
            n_err++; $display("FAIL sat_drained got busy=%b data=%h want busy=0 data=00000302",
                              rbusy[0], rdata[0 +: XLEN]);
        end
        mdl_clock();
    endtask

    task automatic test_simul();
        set_in(1'b0, 0, '0, 1'b1, 9, 1'b0);
        mdl_clock();
        set_in(1'b1, 9, 32'h12345678, 1'b1, 9, 1'b0);
        mdl_clock();
        set_in(1'b0, 0, '0, 1'b0, 0, 1'b0);
        set_rd(9, 0);
        #1;
        n_vec++;
        if (rbusy[0] !== 1'b1) begin
            n_err++; $display("FAIL simul_rbusy got %b want 1", rbusy[0]);
        end
        n_vec++;
        if (rdata[0 +: XLEN] !== 32'h12345678) begin
            n_err++; $display("FAIL simul_rdata got %h want 12345678", rdata[0 +: XLEN]);
        end
        mdl_clock();
    endtask

    task automatic test_flush();
        set_in(1'b0, 0, '0, 1'b1, 4, 1'b0);
        mdl_clock();
        mdl_clock();
        set_in(1'b0, 0, '0, 1'b1, 6, 1'b0);
        mdl_clock();
        set_in(1'b1, 8, 32'hCAFEF00D, 1'b1, 4, 1'b1);
        set_rd(4, 6);
        #1;
        n_vec++;
        if (rbusy !== {m_rbusy(6), m_rbusy(4)}) begin
            n_err++; $display("FAIL flush_same_cycle got %b want %b", rbusy, {m_rbusy(6), m_rbusy(4)});
        end
        mdl_clock();
        set_in(1'b0, 0, '0, 1'b0, 0, 1'b0);
        #1;
        n_vec++;
        if (rbusy !== 2'b00) begin
            n_err++; $display("FAIL flush_cleared got %b want 00", rbusy);
        end
        set_rd(8, 4);
        #1;
        n_vec++;
        if (rdata[0 +: XLEN] !== 32'hCAFEF00D) begin
            n_err++; $display("FAIL flush_write got %h want cafef00d", rdata[0 +: XLEN]);
        end
        mdl_clock();
    endtask

    task automatic test_bypass();
        logic [XLEN-1:0] e_d;
        logic            e_b;
        set_in(1'b1, 2, 32'h0BADF00D, 1'b0, 0, 1'b0);
        mdl_clock();
        set_in(1'b0, 0, '0, 1'b1, 2, 1'b0);
        mdl_clock();
        set_in(1'b1, 2, 32'hA5A5A5A5, 1'b0, 0, 1'b0);
        set_rd(2, 0);
`ifdef REGFILE_BYPASS_EN
        e_d = 32'hA5A5A5A5; e_b = 1'b0;
`else
        e_d = 32'h0BADF00D; e_b = 1'b1;
`endif
        #1;
        n_vec++;
        if (rdata[0 +: XLEN] !== e_d) begin
            n_err++; $display("FAIL bypass_rdata got %h want %h", rdata[0 +: XLEN], e_d);
        end
        n_vec++;
        if (rbusy[0] !== e_b) begin
            n_err++; $display("FAIL bypass_rbusy got %b want %b", rbusy[0], e_b);
        end
        mdl_clock();
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            set_in($urandom_range(0, 1) == 1, $urandom_range(0, 7), $urandom,
                   $urandom_range(0, 9) < 6, $urandom_range(0, 7), $urandom_range(0, 19) == 0);
            set_rd($urandom_range(0, 7), $urandom_range(0, 7));
            #1;
            n_vec++;
            if (iss_rdy !== m_iss_rdy()) begin
                n_err++; $display("FAIL rand%0d_iss_rdy got %b want %b", c, iss_rdy, m_iss_rdy());
            end
            for (int i = 0; i < NRD; i++) begin
                n_vec++;
                if (rdata[i*XLEN +: XLEN] !== m_rdata(raddr[i*AW +: AW]) ||
                    rbusy[i] !== m_rbusy(raddr[i*AW +: AW])) begin
                    n_err++;
                    $display("FAIL rand%0d_port%0d got data=%h busy=%b want data=%h busy=%b",
                             c, i, rdata[i*XLEN +: XLEN], rbusy[i],
                             m_rdata(raddr[i*AW +: AW]), m_rbusy(raddr[i*AW +: AW]));
                end
            end
            mdl_clock();
        end
    endtask

    task automatic test_sweep();
        set_in(1'b0, 0, '0, 1'b0, 0, 1'b0);
        for (int r = 0; r < NREG; r++) begin
            set_rd(r, NREG - 1 - r);
            #1;
            for (int i = 0; i < NRD; i++) begin
                n_vec++;
                if (rdata[i*XLEN +: XLEN] !== m_rdata(raddr[i*AW +: AW]) ||
                    rbusy[i] !== m_rbusy(raddr[i*AW +: AW])) begin
                    n_err++;
                    $display("FAIL sweep_r%0d_port%0d got data=%h busy=%b want data=%h busy=%b",
                             raddr[i*AW +: AW], i, rdata[i*XLEN +: XLEN], rbusy[i],
                             m_rdata(raddr[i*AW +: AW]), m_rbusy(raddr[i*AW +: AW]));
                end
            end
        end
    endtask

    initial begin
        rst = 1'b0;
        set_in(1'b0, 0, '0, 1'b0, 0, 1'b0);
        set_rd(0, 0);
        model_reset();
        #12 rst = 1'b1;
        @(posedge clk);
        #1;
        test_reset();
        test_r0();
        test_saturation();
        test_simul();
        test_flush();
        test_bypass();
        test_random();
        test_sweep();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/regfile_sb.md
# regfile_sb

Parametrised integer register file with NRD combinational read ports, one write port and a per-register pending-write scoreboard. It succeeds the fixed 32x32 two-read file in the core datapath. Decode marks destinations pending on issue; writeback retires them. Read ports report data plus a busy flag so the hazard unit can stall without its own tracking.

## Interface
- XLEN, 32: register data width.
- NREG, 32: number of architectural registers, ≥2.
- NRD, 2: number of read ports, 1..4.
- AW, $clog2(NREG): address width (derived, not overridden).
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous active-low reset.
- raddr  in  NRD*AW  read addresses; port i is bits [i*AW +: AW].
- rdata  out  NRD*XLEN  read data, port i is bits [i*XLEN +: XLEN].
- rbusy  out  NRD  port i register has an outstanding write.
- wen  in  1  writeback strobe.
- waddr  in  AW  writeback address.
- wdata  in  XLEN  writeback data.
- iss_en  in  1  issue strobe; marks iss_addr pending.
- iss_addr  in  AW  destination being issued.
- iss_rdy  out  1  issue accepted this cycle.
- flush  in  1  pipeline flush; clears all pending counts.

## Operation
- Storage: NREG x XLEN array plus a 2-bit pending counter pc[r] per register.
- Register 0 is hardwired: reads return 0, rbusy 0; writes, issues and counts to r0 are ignored. iss_rdy is 1 for r0.
- Write: on wen && waddr!=0, rf[waddr] <= wdata at clk edge. Addresses ≥NREG are ignored. Data is written even during flush.
- Counter update per register r, evaluated each edge:
  - inc = iss_en && iss_rdy && iss_addr==r && !flush.
  - dec = wen && waddr==r && pc[r]!=0 && !flush.
  - flush: pc[r] <= 0 for all r. Flush takes priority over inc and dec.
  - inc && dec: pc unchanged. inc alone: +1. dec alone: −1.
  - A writeback to a register with pc==0 writes data and leaves pc at 0. There is no underflow.
- iss_rdy = !(pc[iss_addr]==3 && !(wen && waddr==iss_addr)). The counter saturates at 3 and refuses a 4th outstanding write unless one retires in the same cycle. iss_rdy is combinational and independent of iss_en.
- Reads are fully combinational. rdata[i] = rf[raddr[i]]. rbusy[i] = (pc[raddr[i]]!=0). Out-of-range raddr returns 0 and busy 0.

## Timing
- Read latency 0 cycles, from raddr to rdata/rbusy.
- Write to read visibility: next cycle without bypass.
- Issue to rbusy high: next cycle.
- Writeback to rbusy low: next cycle, when pc was 1.
- Reset (rst low, async): all rf entries 0, all pc 0. Outputs: rdata 0, rbusy 0, iss_rdy 1. Takes effect mid-operation regardless of clk. Deassertion is synchronised externally.

## Configuration
- REGFILE_BYPASS_EN defined: same-cycle write-to-read forwarding.
  - When wen && waddr!=0 && waddr==raddr[i], rdata[i] = wdata.
  - rbusy[i] reflects the post-writeback count: it is 0 if pc==1, no matching issue is accepted this cycle, and flush is low.
  - Flush combinationally forces rbusy low.
- Macro undefined: no forwarding.
  - rdata and rbusy come from registered state only.
  - The write is visible one cycle later.

## Test plan
- Reset: write 0xDEADBEEF to r5 and issue r7. Pulse rst low between edges. Expect rdata(r5)=0, rbusy(r7)=0, iss_rdy=1 immediately.
- r0: wen waddr=0 wdata=0xFFFFFFFF, and iss r0. Expect rdata(r0)=0 and rbusy=0 on the next cycle.
- Scoreboard:
  - Issue r3 three times; expect iss_rdy=0 on the 4th.
  - The 4th issue together with a wen r3 is accepted; pc stays 3.
  - Three writebacks take rbusy(r3) from 1 to 0 after the third.
- Simultaneous issue and writeback on r9 with pc=1: pc stays 1 and rbusy(r9)=1. Write r9=0x12345678, then read it next cycle: expect 0x12345678.
- Flush: pc(r4)=2, pc(r6)=1, flush with iss r4. Next cycle expect rbusy(r4)=rbusy(r6)=0. A write in the same cycle lands.
- Bypass (macro on): pc(r2)=1, wen r2=0xA5A5A5A5, raddr0=r2. Same cycle: rdata0=0xA5A5A5A5, rbusy0=0. Macro off: old value, busy 1.
